// File: rtl/mod_casex_mask_pattern_emitter_pkg.sv
// Shared types and constants for the casex mask pattern emitter.
//   match_type_t : 2-bit classification produced by the priority mask classifier
//   state_t      : emitter FSM states
//   MASK_W       : candidate mask width
//   PROBE_W      : probe counter width (counts 1..16)
package casex_mask_pkg;

  localparam int MASK_W  = 4;
  localparam int PROBE_W = 5;

  typedef enum logic [1:0] {
    MT_BIT2_SET  = 2'b00,
    MT_DEFAULT   = 2'b01,
    MT_LOW_CLEAR = 2'b10,
    MT_HIGH_ZERO = 2'b11
  } match_type_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SEARCH = 2'b01,
    ST_HOLD   = 2'b10
  } state_t;

endpackage : casex_mask_pkg

// File: rtl/mod_casex_mask_pattern_emitter_classifier.sv
// Combinational priority classifier for a 4-bit mask (first hit wins):
//   m[3]=1 & m[1]=0 -> MT_LOW_CLEAR
//   m[3]=1 & m[2]=0 -> MT_HIGH_ZERO
//   m[2]=1          -> MT_BIT2_SET
//   otherwise       -> MT_DEFAULT
// Ports:
//   mask_i  in  MASK_W   mask to classify
//   type_o  out 2        resulting match type
module mod_casex_mask_classifier
  import casex_mask_pkg::*;
(
  input  logic [MASK_W-1:0] mask_i,
  output match_type_t       type_o
);

  always_comb begin
    if (mask_i[3] && !mask_i[1]) begin
      type_o = MT_LOW_CLEAR;
    end else if (mask_i[3] && !mask_i[2]) begin
      type_o = MT_HIGH_ZERO;
    end else if (mask_i[2]) begin
      type_o = MT_BIT2_SET;
    end else begin
      type_o = MT_DEFAULT;
    end
  end

endmodule : mod_casex_mask_classifier

// File: rtl/mod_casex_mask_pattern_emitter.sv
// Inverse of the priority mask classifier: given a requested match type,
// searches candidate masks one per cycle starting from a rotating seed and
// emits the first mask that classifies to that type.
// Ports:
//   clk         in   1  clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   req_valid   in   1  request present
//   req_ready   out  1  block can accept a request (IDLE only)
//   req_type    in   2  requested match type
//   out_valid   out  1  result present
//   out_ready   in   1  consumer accepts the result
//   out_mask    out  4  mask whose classification equals the captured type
//   out_probes  out  5  number of candidates examined, 1..16
module mod_casex_mask_pattern_emitter
  import casex_mask_pkg::*;
#(
  parameter logic [MASK_W-1:0] SEED_INIT = 4'h0,
  parameter logic [MASK_W-1:0] SEED_STEP = 4'h1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_type,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [MASK_W-1:0]  out_mask,
  output logic [PROBE_W-1:0] out_probes
);

  state_t              state_q,      state_d;
  match_type_t         type_q,       type_d;
  logic [MASK_W-1:0]   seed_q,       seed_d;
  logic [MASK_W-1:0]   cand_q,       cand_d;
  logic [PROBE_W-1:0]  probes_q,     probes_d;
  logic                out_valid_q,  out_valid_d;
  logic [MASK_W-1:0]   out_mask_q,   out_mask_d;
  logic [PROBE_W-1:0]  out_probes_q, out_probes_d;
  logic                req_ready_q,  req_ready_d;

  match_type_t         cand_type;

  mod_casex_mask_classifier u_classifier (
    .mask_i (cand_q),
    .type_o (cand_type)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    type_d       = type_q;
    seed_d       = seed_q;
    cand_d       = cand_q;
    probes_d     = probes_q;
    out_valid_d  = out_valid_q;
    out_mask_d   = out_mask_q;
    out_probes_d = out_probes_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          type_d   = match_type_t'(req_type);
          cand_d   = seed_q;
          probes_d = '0;
          state_d  = ST_SEARCH;
        end
      end

      ST_SEARCH: begin
        probes_d = probes_q + PROBE_W'(1);
        if (cand_type == type_q) begin
          out_mask_d   = cand_q;
          out_probes_d = probes_q + PROBE_W'(1);
          state_d      = ST_HOLD;
        end else begin
          // Natural 4-bit wrap takes 4'hF back to 4'h0.
          cand_d = cand_q + MASK_W'(1);
        end
      end

      ST_HOLD: begin
        // The result registers are loaded on entry; out_valid is published
        // one cycle later, giving the two-cycle minimum latency.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          seed_d      = seed_q + SEED_STEP;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Registered ready: asserted exactly when the next state is IDLE, so it
    // is high on the handshake edge and never depends combinationally on req_*.
    req_ready_d = (state_d == ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      type_q       <= MT_BIT2_SET;
      seed_q       <= SEED_INIT;
      cand_q       <= '0;
      probes_q     <= '0;
      out_valid_q  <= 1'b0;
      out_mask_q   <= '0;
      out_probes_q <= '0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      seed_q       <= seed_d;
      cand_q       <= cand_d;
      probes_q     <= probes_d;
      out_valid_q  <= out_valid_d;
      out_mask_q   <= out_mask_d;
      out_probes_q <= out_probes_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign out_valid  = out_valid_q;
  assign out_mask   = out_mask_q;
  assign out_probes = out_probes_q;

endmodule : mod_casex_mask_pattern_emitter

// File: doc/mod_casex_mask_pattern_emitter.md
# mod_casex_mask_pattern_emitter

Inverse of the priority casex mask classifier: accepts a requested 2-bit match type and emits a 4-bit mask that the classifier maps to that type. The block searches candidate masks sequentially, one per cycle, from a rotating seed, so successive requests yield varied masks. It sits upstream of classifier instances as a stimulus and self-check source, with valid/ready handshakes on both sides.

## Interface
- `SEED_INIT`, default 4'h0: seed value after reset.
- `SEED_STEP`, default 4'h1: amount added to the seed (mod 16) after each completed output handshake.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_type`  in  2  requested match type.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `out_mask`  out  4  mask whose classification equals the captured type.
- `out_probes`  out  5  number of candidates examined, 1..16.

## Operation
- Classification rules, 2-state, priority order (first hit wins):
  - m[3]=1 & m[1]=0 → 2'b10.
  - m[3]=1 & m[2]=0 → 2'b11.
  - m[2]=1 → 2'b00.
  - Otherwise → 2'b01.
- FSM states: IDLE, SEARCH, HOLD.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&`req_ready`: capture `req_type`, cand←seed, probes←0, go to SEARCH.
- SEARCH: each cycle, classify cand.
  - Match: `out_mask`←cand, `out_probes`←probes+1, go to HOLD.
  - No match: cand←cand+1 (4'hF wraps to 4'h0), probes←probes+1.
- HOLD:
  - `out_valid`=1; `out_mask` and `out_probes` stay stable until `out_ready`.
  - On the handshake: seed←seed+`SEED_STEP` mod 16, go to IDLE.
- Every type is reachable, so a search ends within 16 probes. No error path exists.
- `req_ready`=0 outside IDLE. A request held during SEARCH or HOLD waits and is not lost.
- Reset (any state, including mid-search or HOLD):
  - state=IDLE, seed=`SEED_INIT`, cand=0, probes=0.
  - `out_valid`=0, `out_mask`=0, `out_probes`=0, `req_ready`=1 after reset deasserts.

## Timing
- Request accepted at edge T. The first probe happens in cycle T+1.
- `out_valid` rises at edge T+1+N, where N=`out_probes`. Minimum latency is 2 cycles (N=1).
- Output handshake at edge H: `out_valid`=0 and `req_ready`=1 from H onward. The next request can be accepted at edge H+1.
- The seed update takes effect for the request accepted after H.
- All outputs are registered. There is no combinational path from `req_*` or `out_ready` to any output.

## Structure
- Package `casex_mask_pkg`:
  - `match_type_t` enum: MT_BIT2_SET=2'b00, MT_DEFAULT=2'b01, MT_LOW_CLEAR=2'b10, MT_HIGH_ZERO=2'b11.
  - FSM state enum.
  - Width constants (MASK_W=4, PROBE_W=5).
- Sub-module `mod_casex_mask_classifier`: combinational, 4-bit mask in, `match_type_t` out, implementing the priority rules above. It is instantiated once on cand and reused by the bench as the reference model.

## Test plan
- Reset, then `req_type`=01 → `out_mask`=4'b0000, `out_probes`=1, `out_valid` 2 cycles after accept. Next seed=1.
- After reset, `req_type`=10 → `out_mask`=4'b1000, `out_probes`=9. With `req_type`=11 instead (fresh reset) → `out_mask`=4'b1010, `out_probes`=11.
- Back-to-back: `req_type`=01, then 00 → masks 4'b0000 (probes 1), then 4'b0100 (probes 4, from seed 1).
- Wrap-around: after 15 completed requests, seed=4'hF; `req_type`=01 → 4'hF classifies as 00 and is skipped, then `out_mask`=4'b0000 with `out_probes`=2.
- Backpressure: hold `out_ready`=0 for 5 cycles in HOLD → `out_valid`, `out_mask` and `out_probes` stable, `req_ready`=0, and a pending `req_valid` is not accepted until the cycle after the output handshake.
- Reset asserted mid-SEARCH (`req_type`=11, 4 probes in) → `out_valid`=0 immediately, seed back to `SEED_INIT`, and the next `req_type`=11 returns 4'b1010 with probes 11.
